// File: rtl/seq_alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seq_alu_pkg
//  Description : Opcodes, FSM state encoding and helpers shared by the
//                sequential accumulator ALU.
//  Revision    : 1.0 - initial release
// ============================================================================
package seq_alu_pkg;

    localparam logic [3:0] c_OP_AND  = 4'd0;
    localparam logic [3:0] c_OP_ADD  = 4'd1;
    localparam logic [3:0] c_OP_CLA  = 4'd2;
    localparam logic [3:0] c_OP_CMA  = 4'd3;
    localparam logic [3:0] c_OP_CIR  = 4'd4;
    localparam logic [3:0] c_OP_CIL  = 4'd5;
    localparam logic [3:0] c_OP_INC  = 4'd6;
    localparam logic [3:0] c_OP_CLE  = 4'd7;
    localparam logic [3:0] c_OP_CME  = 4'd8;
    localparam logic [3:0] c_OP_SPA  = 4'd9;
    localparam logic [3:0] c_OP_SNA  = 4'd10;
    localparam logic [3:0] c_OP_SZA  = 4'd11;
    localparam logic [3:0] c_OP_SZE  = 4'd12;
    localparam logic [3:0] c_OP_LDA  = 4'd13;
    localparam logic [3:0] c_OP_LDAI = 4'd14;
    localparam logic [3:0] c_OP_MUL  = 4'd15;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ITER = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Operations that run through the multi-cycle iteration datapath
    function automatic logic is_iter(input logic [3:0] op);
        return (op == c_OP_CIR) || (op == c_OP_CIL) || (op == c_OP_MUL);
    endfunction

endpackage
`default_nettype wire

// File: rtl/seq_alu_if.sv
`default_nettype none
// ============================================================================
//  Module      : seq_alu_if
//  Description : Request/response bus between the control unit (master) and
//                the sequential ALU (slave).
//  Revision    : 1.0 - initial release
// ============================================================================
interface seq_alu_if #(
    parameter int W     = 16,
    parameter int IMM_W = W - 8,
    parameter int SH_W  = $clog2(W + 1)
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       op;
    logic [W-1:0]     op1;
    logic [W-1:0]     op2;
    logic [IMM_W-1:0] imm;
    logic [SH_W-1:0]  shamt;
    logic             out_valid;
    logic             out_ready;
    logic [W-1:0]     result;
    logic             skip;
    logic             E;
    logic             Z;
    logic             N;

    modport master (
        output in_valid, op, op1, op2, imm, shamt, out_ready,
        input  in_ready, out_valid, result, skip, E, Z, N
    );

    modport slave (
        input  in_valid, op, op1, op2, imm, shamt, out_ready,
        output in_ready, out_valid, result, skip, E, Z, N
    );
endinterface
`default_nettype wire

// File: rtl/seq_alu_iter.sv
`default_nettype none
// ============================================================================
//  Module      : seq_alu_iter
//  Description : Iteration datapath: (W+1)-bit rotate ring that doubles as the
//                partial-product register, multiplier shift register and a
//                step down-counter. Sequenced by the parent FSM.
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_alu_iter
    import seq_alu_pkg::*;
#(
    parameter int W  = 16,
    parameter int CW = $clog2(W + 2)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_load,
    input  logic          i_step,
    input  logic [3:0]    i_op,
    input  logic [W-1:0]  i_a,
    input  logic [W-1:0]  i_b,
    input  logic          i_e,
    input  logic [CW-1:0] i_count,
    output logic          o_last,
    output logic [W-1:0]  o_result,
    output logic          o_e
);

    logic [3:0]    r_op;
    logic [W:0]    r_ring;
    logic [W-1:0]  r_mq;
    logic [W-1:0]  r_mcand;
    logic [CW-1:0] r_cnt;

    logic [W:0]    w_sum;
    logic [W:0]    w_ring_next;
    logic [W-1:0]  w_mq_next;

    // One iteration step: rotate the {AC,E} ring, or one shift-add of the multiply
    always_comb begin
        w_sum       = {1'b0, r_ring[W-1:0]} + (r_mq[0] ? {1'b0, r_mcand} : {(W+1){1'b0}});
        w_ring_next = r_ring;
        w_mq_next   = r_mq;
        case (r_op)
            c_OP_CIL: w_ring_next = {r_ring[W-1:0], r_ring[W]};
            c_OP_CIR: w_ring_next = {r_ring[0], r_ring[W:1]};
            c_OP_MUL: begin
                // Carry and sum shift right together; low product bits
                // enter the top of the multiplier register.
                w_ring_next = {1'b0, w_sum[W:1]};
                w_mq_next   = {w_sum[0], r_mq[W-1:1]};
            end
            default: ;
        endcase
    end

    // Load operands on accept, then advance one step per cycle while counting down
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op    <= c_OP_AND;
            r_ring  <= '0;
            r_mq    <= '0;
            r_mcand <= '0;
            r_cnt   <= '0;
        end else if (i_load) begin
            r_op    <= i_op;
            r_ring  <= (i_op == c_OP_MUL) ? {(W+1){1'b0}} : {i_a, i_e};
            r_mq    <= i_a;
            r_mcand <= i_b;
            r_cnt   <= i_count;
        end else if (i_step) begin
            r_ring  <= w_ring_next;
            r_mq    <= w_mq_next;
            r_cnt   <= r_cnt - CW'(1);
        end
    end

    // The result presented is what the current (possibly final) step produces
    assign o_last   = (r_cnt == CW'(1));
    assign o_result = (r_op == c_OP_MUL) ? w_mq_next : w_ring_next[W:1];
    assign o_e      = (r_op == c_OP_MUL) ? (|w_ring_next[W-1:0]) : w_ring_next[0];

endmodule
`default_nettype wire

// File: rtl/seq_alu.sv
`default_nettype none
// ============================================================================
//  Module      : seq_alu
//  Description : Registered accumulator ALU with valid/ready handshake,
//                link flag E, Z/N flags, multi-position rotate-through-E and
//                shift-add multiply.
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_alu
    import seq_alu_pkg::*;
#(
    parameter int W     = 16,
    parameter int IMM_W = W - 8,
    parameter int SH_W  = $clog2(W + 1)
) (
    input  logic      CLK,
    input  logic      RST_N,
    seq_alu_if.slave  bus
);

    // Counter must hold W+1 (full-ring rotate)
    localparam int CW = $clog2(W + 2);

    state_t           r_state;
    state_t           w_state_next;
    logic [3:0]       r_op;
    logic [W-1:0]     r_op1;
    logic [W-1:0]     r_op2;
    logic [IMM_W-1:0] r_imm;
    logic             r_out_valid;
    logic [W-1:0]     r_result;
    logic             r_skip;
    logic             r_e;
    logic             r_z;
    logic             r_n;

    logic             w_idle_ready;
    logic             w_accept;
    logic             w_load;
    logic             w_step;
    logic             w_commit_single;
    logic             w_commit_iter;
    logic             w_release;
    logic [CW-1:0]    w_count;
    logic             w_it_last;
    logic [W-1:0]     w_it_result;
    logic             w_it_e;
    logic [W-1:0]     w_sc_result;
    logic             w_sc_skip;
    logic             w_sc_e;
    logic             w_sc_upd_zn;

    assign w_idle_ready = (r_state == ST_IDLE) && !r_out_valid;

    // State register
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) r_state <= ST_IDLE;
        else        r_state <= w_state_next;
    end

    // Next state and datapath strobes; DONE first computes single-cycle ops
    // (out_valid still low) and then waits for the consumer.
    always_comb begin
        w_state_next    = r_state;
        w_accept        = 1'b0;
        w_load          = 1'b0;
        w_step          = 1'b0;
        w_commit_single = 1'b0;
        w_commit_iter   = 1'b0;
        w_release       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.in_valid && w_idle_ready) begin
                    w_accept = 1'b1;
                    if (is_iter(bus.op)) begin
                        w_load       = 1'b1;
                        w_state_next = ST_ITER;
                    end else begin
                        w_state_next = ST_DONE;
                    end
                end
            end
            ST_ITER: begin
                w_step = 1'b1;
                if (w_it_last) begin
                    w_commit_iter = 1'b1;
                    w_state_next  = ST_DONE;
                end
            end
            ST_DONE: begin
                if (!r_out_valid) begin
                    w_commit_single = 1'b1;
                end else if (bus.out_ready) begin
                    w_release    = 1'b1;
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Step count: MUL runs W steps; rotate count 0 means 1, oversize clamps to W+1
    always_comb begin
        w_count = CW'(bus.shamt);
        if (bus.op == c_OP_MUL)               w_count = CW'(W);
        else if (bus.shamt == '0)             w_count = CW'(1);
        else if (CW'(bus.shamt) > CW'(W))     w_count = CW'(W + 1);
    end

    // Single-cycle operation results from the captured operands
    always_comb begin
        w_sc_result = '0;
        w_sc_skip   = 1'b0;
        w_sc_e      = r_e;
        w_sc_upd_zn = 1'b1;
        case (r_op)
            c_OP_AND:  w_sc_result = r_op1 & r_op2;
            c_OP_ADD:  {w_sc_e, w_sc_result} = {1'b0, r_op1} + {1'b0, r_op2};
            c_OP_CLA:  w_sc_result = '0;
            c_OP_CMA:  w_sc_result = ~r_op1;
            c_OP_INC:  w_sc_result = r_op1 + W'(1);
            c_OP_CLE: begin w_sc_e = 1'b0; w_sc_upd_zn = 1'b0; end
            c_OP_CME: begin w_sc_e = ~r_e; w_sc_upd_zn = 1'b0; end
            c_OP_SPA: begin w_sc_skip = !r_op1[W-1] && (|r_op1); w_sc_upd_zn = 1'b0; end
            c_OP_SNA: begin w_sc_skip = r_op1[W-1];              w_sc_upd_zn = 1'b0; end
            c_OP_SZA: begin w_sc_skip = (r_op1 == '0);           w_sc_upd_zn = 1'b0; end
            c_OP_SZE: begin w_sc_skip = !r_e;                    w_sc_upd_zn = 1'b0; end
            c_OP_LDA:  w_sc_result = r_op2;
            c_OP_LDAI: w_sc_result = W'(r_imm);
            default:   w_sc_result = '0;
        endcase
    end

    seq_alu_iter #(
        .W  (W),
        .CW (CW)
    ) u_iter (
        .clk      (CLK),
        .rst_n    (RST_N),
        .i_load   (w_load),
        .i_step   (w_step),
        .i_op     (bus.op),
        .i_a      (bus.op1),
        .i_b      (bus.op2),
        .i_e      (r_e),
        .i_count  (w_count),
        .o_last   (w_it_last),
        .o_result (w_it_result),
        .o_e      (w_it_e)
    );

    // Capture the request at the accept edge
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_op  <= c_OP_AND;
            r_op1 <= '0;
            r_op2 <= '0;
            r_imm <= '0;
        end else if (w_accept) begin
            r_op  <= bus.op;
            r_op1 <= bus.op1;
            r_op2 <= bus.op2;
            r_imm <= bus.imm;
        end
    end

    // Commit result and flags together with out_valid; hold until consumed
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_skip      <= 1'b0;
            r_e         <= 1'b0;
            r_z         <= 1'b0;
            r_n         <= 1'b0;
        end else if (w_commit_single) begin
            r_out_valid <= 1'b1;
            r_result    <= w_sc_result;
            r_skip      <= w_sc_skip;
            r_e         <= w_sc_e;
            if (w_sc_upd_zn) begin
                r_z <= (w_sc_result == '0);
                r_n <= w_sc_result[W-1];
            end
        end else if (w_commit_iter) begin
            r_out_valid <= 1'b1;
            r_result    <= w_it_result;
            r_skip      <= 1'b0;
            r_e         <= w_it_e;
            r_z         <= (w_it_result == '0);
            r_n         <= w_it_result[W-1];
        end else if (w_release) begin
            r_out_valid <= 1'b0;
        end
    end

    // in_ready is forced low while reset is asserted
    assign bus.in_ready  = RST_N && w_idle_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.result    = r_result;
    assign bus.skip      = r_skip;
    assign bus.E         = r_e;
    assign bus.Z         = r_z;
    assign bus.N         = r_n;

endmodule
`default_nettype wire
